rst_seq_ctrl: RTL and testbench
===============================

// Module: rst_seq_ctrl
// PURPOSE
// Reset sequencer for the NPC core. Takes the already-synchronised, active-low system reset plus
// soft-reset requests (e.g. debug, watchdog) and arbitrates between them. Drives a thermometer
// set of per-stage active-low resets: all are held for a minimum time, then released in order,
// stage 0 first (e.g. regfile/CSR, then pipeline, then memory interface).
// PARAMETERS
// NUM_STAGES   3   number of sequenced reset outputs (>=1)
// NUM_REQ      2   number of soft-reset requesters (>=1)
// HOLD_CYCLES  16  edges all stage resets stay asserted after sequence entry (>=1)
// STAGE_GAP    4   edges between successive stage releases (>=1)
// PORTS
// clk           in   1             core clock; all logic on posedge
// rstn          in   1             reset, synchronous, active-low
// req_i         in   NUM_REQ       soft-reset request, level, held until acked
// req_ack_o     out  NUM_REQ       one-cycle pulse, one-hot: request accepted, sequence started
// stage_rstn_o  out  NUM_STAGES    per-stage active-low resets, thermometer-coded
// busy_o        out  1             1 while any stage reset is asserted
// ready_o       out  1             1 when all stages released (state RUN)
// cause_o       out  NUM_REQ+1     one-hot cause of last sequence; bit0=rstn, bit i+1=req_i[i]
// BEHAVIOUR
// - Reset (rstn sampled 0 at posedge, any state): state ASSERT; stage_rstn_o=0, busy_o=1,
//   ready_o=0, req_ack_o=0, cause_o=1 (bit0), counter=0. rstn low dominates all other inputs.
// - States: ASSERT -> HOLD -> RELEASE -> RUN; RUN -> HOLD on accepted soft request.
// - Entry edge Ex: the edge where ASSERT sees rstn=1, or where RUN accepts a request. Ex enters
//   HOLD with counter=0 and all stage resets asserted.
// - Stage k deasserts (bit goes 1) at edge Ex + HOLD_CYCLES + k*STAGE_GAP.
//   Last stage release: state=RUN, ready_o=1, busy_o=0 on that same edge.
// - Full sequence length: HOLD_CYCLES + (NUM_STAGES-1)*STAGE_GAP edges after Ex.
// - stage_rstn_o is always thermometer: bit k=1 implies bits 0..k-1 = 1; no glitches,
//   all outputs registered.
// - Arbitration: requests are sampled only in RUN, with fixed priority (lowest index wins).
//   On acceptance at Ex:
//   - req_ack_o[i]=1 for exactly that one cycle;
//   - cause_o = 1<<(i+1);
//   - stage_rstn_o=0, ready_o=0, busy_o=1.
// - Requests asserted in ASSERT/HOLD/RELEASE are not acked and not dropped. A level still high
//   on reaching RUN is accepted on the first RUN-sampling edge, i.e. the edge after ready_o rises.
// - A requester still high after its ack is treated as a new request: this starts another
//   sequence. Requesters must deassert on ack.
// - rstn low mid-HOLD/RELEASE/RUN: next edge -> ASSERT, all outputs to reset values, no ack,
//   cause_o=1. The sequence restarts from the edge where rstn is sampled 1.
// - Counter width $clog2(max(HOLD_CYCLES,STAGE_GAP)+1). It saturates/reloads per phase and
//   never wraps into a spurious release.
// TESTING (defaults: NUM_STAGES=3, NUM_REQ=2, HOLD=16, GAP=4)
// 1 Power-on: rstn=0 for 5 edges, then 1; E1 = first edge with rstn=1
//   -> stage=000 until E17; 001@E17, 011@E21, 111+ready_o=1@E25; cause_o=001, req_ack_o=0 always.
// 2 In RUN, req_i=10 at edge Ea -> req_ack_o=10 for 1 cycle, cause_o=100, stage=000@Ea,
//   001@Ea+16, 011@Ea+20, 111@Ea+24.
// 3 In RUN, req_i=11 -> ack=01 only, cause_o=010; req[1] kept high
//   -> ack=10 on the edge after ready_o rises, cause_o=100.
// 4 rstn=0 for 1 edge while stage=001 -> stage=000, cause_o=001, no ack;
//   release repeats at +16/+20/+24 from the next rstn=1 edge.
// 5 req_i=01 raised during HOLD -> no ack before ready_o; ack=01 on the first RUN-sampling edge.
// 6 Param sweep NUM_STAGES=1, HOLD=1, GAP=1 -> stage_rstn_o=1 and ready_o=1 at Ex+1;
//   thermometer invariant asserted throughout all runs.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: arbitrates system reset and soft-reset requests, releases per-stage resets in order.
// Latency: stage k releases HOLD_CYCLES + k*STAGE_GAP edges after sequence entry; all outputs registered.
// Backpressure: requests are level-held and only sampled in RUN; requests seen earlier wait, never drop.
module rst_seq_ctrl #(
    parameter int NUM_STAGES  = 3,
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req_i,
    output logic [NUM_REQ-1:0]    req_ack_o,
    output logic [NUM_STAGES-1:0] stage_rstn_o,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [NUM_REQ:0]      cause_o
);

    // The counter only has to reach the longer of the two phase lengths.
    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int CAW     = NUM_REQ + 1;

    localparam logic [CW-1:0]         HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]         GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [NUM_STAGES-1:0] STG_LSB   = NUM_STAGES'(1);
    localparam logic [NUM_REQ-1:0]    REQ_LSB   = NUM_REQ'(1);
    localparam logic [NUM_REQ:0]      CAUSE_POR = CAW'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]   stage_q, stage_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic [NUM_REQ:0]        cause_q, cause_d;

    logic [NUM_REQ-1:0]      grant;
    logic [NUM_STAGES-1:0]   stage_shift;

    // Fixed-priority pick: scanning high to low lets the lowest set index win.
    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant = REQ_LSB << i;
            end
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        ack_d       = '0;
        cause_d     = cause_q;
        // Releasing one more stage shifts a 1 in at bit 0, keeping the thermometer shape.
        stage_shift = (stage_q << 1) | STG_LSB;

        case (state_q)
            ST_ASSERT: begin
                // Only reachable with rstn already high here: this edge is sequence entry.
                state_d = ST_HOLD;
                cnt_d   = '0;
                stage_d = '0;
                busy_d  = 1'b1;
                ready_d = 1'b0;
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    stage_d = stage_shift;
                    cnt_d   = '0;
                    if (&stage_shift) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    stage_d = stage_shift;
                    cnt_d   = '0;
                    if (&stage_shift) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                // Soft requests are honoured only once the core is fully out of reset.
                if (|req_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    stage_d = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    ack_d   = grant;
                    cause_d = {grant, 1'b0};
                end
            end

            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
                stage_d = '0;
                busy_d  = 1'b1;
                ready_d = 1'b0;
                cause_d = CAUSE_POR;
            end
        endcase
    end

    // State and output registers; system reset overrides everything including a pending request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            stage_q <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            ack_q   <= '0;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            cause_q <= cause_d;
        end
    end

    assign req_ack_o    = ack_q;
    assign stage_rstn_o = stage_q;
    assign busy_o       = busy_q;
    assign ready_o      = ready_q;
    assign cause_o      = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: default instance plus a minimal one (1 stage, hold 1, gap 1) side by side.
// A timeline model (entry edge + arithmetic release times) predicts outputs per edge into a queue.
// A negedge monitor pops the queue and compares both instances every cycle.
module tb_rst_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [1:0] req_a, req_b;
    logic [1:0] ack_a, ack_b;
    logic [2:0] stage_a;
    logic       stage_b;
    logic       busy_a, ready_a, busy_b, ready_b;
    logic [2:0] cause_a, cause_b;

    rst_seq_ctrl #(.NUM_STAGES(3), .NUM_REQ(2), .HOLD_CYCLES(16), .STAGE_GAP(4)) dut_a (
        .clk(clk), .rstn(rstn), .req_i(req_a), .req_ack_o(ack_a),
        .stage_rstn_o(stage_a), .busy_o(busy_a), .ready_o(ready_a), .cause_o(cause_a)
    );

    rst_seq_ctrl #(.NUM_STAGES(1), .NUM_REQ(2), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut_b (
        .clk(clk), .rstn(rstn), .req_i(req_b), .req_ack_o(ack_b),
        .stage_rstn_o(stage_b), .busy_o(busy_b), .ready_o(ready_b), .cause_o(cause_b)
    );

    typedef struct packed {
        logic [2:0] stage;
        logic       busy;
        logic       ready;
        logic [1:0] ack;
        logic [2:0] cause;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } pair_t;

    pair_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    bit tmo_flag = 1'b0;
    bit tmo_seen = 1'b0;

    int p_n[2] = '{3, 1};
    int p_h[2] = '{16, 1};
    int p_g[2] = '{4, 1};

    int         m_ex[2]    = '{0, 0};
    bit         m_rst[2]   = '{1'b1, 1'b1};
    logic [2:0] m_cause[2] = '{3'b001, 3'b001};

    // Reference timeline: track only "in reset", entry edge and cause; outputs follow by arithmetic.
    always @(posedge clk) begin
        pair_t p;
        obs_t  o;
        edge_n++;
        p = '0;
        for (int i = 0; i < 2; i++) begin
            logic [1:0] r;
            logic [1:0] ack;
            int         len;
            r   = (i == 0) ? req_a : req_b;
            len = p_h[i] + (p_n[i] - 1) * p_g[i];
            ack = 2'b00;
            if (!rstn) begin
                m_rst[i]   = 1'b1;
                m_cause[i] = 3'b001;
            end else if (m_rst[i]) begin
                m_rst[i] = 1'b0;
                m_ex[i]  = edge_n;
            end else if (edge_n > m_ex[i] + len && r != 2'b00) begin
                ack        = r[0] ? 2'b01 : 2'b10;
                m_cause[i] = {ack, 1'b0};
                m_ex[i]    = edge_n;
            end
            o       = '0;
            o.ack   = ack;
            o.cause = m_cause[i];
            if (m_rst[i]) begin
                o.busy  = 1'b1;
                o.ready = 1'b0;
            end else begin
                for (int k = 0; k < p_n[i]; k++)
                    o.stage[k] = (edge_n >= m_ex[i] + p_h[i] + k * p_g[i]);
                o.ready = (edge_n >= m_ex[i] + len);
                o.busy  = !o.ready;
            end
            if (i == 0) p.a = o;
            else        p.b = o;
        end
        exp_q.push_back(p);
    end

    // Monitor: one expected entry per edge, checked half a cycle later.
    always @(negedge clk) begin
        pair_t p;
        obs_t  got_a, got_b;
        if (tmo_flag && !tmo_seen) begin
            tmo_seen = 1'b1;
            total++;
            bad++;
            $display("FAIL wait_stage_001 timed out: got stage=%b required=001", stage_a);
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty at edge %0d: got no expectation, required one", edge_n);
        end else begin
            p     = exp_q.pop_front();
            got_a = {stage_a, busy_a, ready_a, ack_a, cause_a};
            got_b = {2'b00, stage_b, busy_b, ready_b, ack_b, cause_b};
            total++;
            if (got_a !== p.a) begin
                bad++;
                $display("FAIL dut_a edge=%0d got stage=%b busy=%b ready=%b ack=%b cause=%b required stage=%b busy=%b ready=%b ack=%b cause=%b",
                         edge_n, got_a.stage, got_a.busy, got_a.ready, got_a.ack, got_a.cause,
                         p.a.stage, p.a.busy, p.a.ready, p.a.ack, p.a.cause);
            end
            total++;
            if (got_b !== p.b) begin
                bad++;
                $display("FAIL dut_b edge=%0d got stage=%b busy=%b ready=%b ack=%b cause=%b required stage=%b busy=%b ready=%b ack=%b cause=%b",
                         edge_n, got_b.stage, got_b.busy, got_b.ready, got_b.ack, got_b.cause,
                         p.b.stage, p.b.busy, p.b.ready, p.b.ack, p.b.cause);
            end
            total++;
            if (!(stage_a == 3'b000 || stage_a == 3'b001 || stage_a == 3'b011 || stage_a == 3'b111)) begin
                bad++;
                $display("FAIL thermometer edge=%0d got stage=%b required thermometer code", edge_n, stage_a);
            end
        end
    end

    // Advance one cycle; requesters drop any bit that was just acknowledged.
    task automatic step();
        @(negedge clk);
        #1;
        req_a = req_a & ~ack_a;
        req_b = req_b & ~ack_b;
    endtask

    initial begin : stim
        int         rst_left;
        int         n;
        logic [1:0] r;
        rstn  = 1'b0;
        req_a = 2'b00;
        req_b = 2'b00;

        // Power-on: five reset edges then the full release sequence.
        repeat (5) step();
        rstn = 1'b1;
        repeat (30) step();

        // Single request from requester 1.
        req_a = 2'b10; req_b = 2'b10;
        repeat (30) step();

        // Both request: requester 0 first, requester 1 right after the next ready.
        req_a = 2'b11; req_b = 2'b11;
        repeat (60) step();

        // System reset while only stage 0 is released.
        req_a = 2'b01; req_b = 2'b01;
        n = 0;
        while (stage_a !== 3'b001 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) tmo_flag = 1'b1;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        repeat (30) step();

        // Request raised during HOLD waits for RUN.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        repeat (4) step();
        req_a = req_a | 2'b01; req_b = req_b | 2'b01;
        repeat (60) step();

        // Random mix of reset pulses and request levels.
        rst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rstn = 1'b1;
            end else if ($urandom_range(0, 249) == 0) begin
                rstn     = 1'b0;
                rst_left = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 29) == 0) begin
                r     = 2'($urandom_range(1, 3));
                req_a = req_a | r;
                req_b = req_b | r;
            end
        end
        rstn = 1'b1;
        repeat (80) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
